// File: rtl/miriscv_timer_periph.sv
// Memory-mapped down-counting timer with auto-reload and a pending/overrun
// status pair; raises int_req_o until the interrupt controller acknowledges.
module miriscv_timer_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int unsigned CNT_W     = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        int_req_o,
    input  logic        int_fin_i
);

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    logic             en_q, en_d, auto_q, auto_d, ie_q, ie_d;
    logic             pend_q, pend_d, ovr_q, ovr_d;
    logic [CNT_W-1:0] load_q, load_d, count_q, count_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        hit, wr, rd, expire, start;
    logic        wr_ctrl, wr_load, wr_count, wr_stat;
    logic [1:0]  sel;
    logic [31:0] load_ext, count_ext, load_wr, count_wr;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^data_addr_i[1:0];

    assign hit = data_req_i && (data_addr_i[31:4] == BASE_ADDR[31:4]);
    assign wr  = hit && data_we_i;
    assign rd  = hit && !data_we_i;
    assign sel = data_addr_i[3:2];

    // Enable bits live in lane 0 only, so other lanes never touch them
    assign wr_ctrl  = wr && (sel == 2'd0) && data_be_i[0];
    assign wr_load  = wr && (sel == 2'd1);
    assign wr_count = wr && (sel == 2'd2);
    assign wr_stat  = wr && (sel == 2'd3) && data_be_i[0];

    assign expire = en_q && (count_q == '0);
    assign start  = wr_ctrl && !en_q && data_wdata_i[0];

    always_comb begin
        load_ext             = '0;
        count_ext            = '0;
        load_ext[CNT_W-1:0]  = load_q;
        count_ext[CNT_W-1:0] = count_q;
    end

    assign load_wr  = merge(load_ext, data_wdata_i, data_be_i);
    assign count_wr = merge(count_ext, data_wdata_i, data_be_i);

    always_comb begin
        en_d    = en_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        load_d  = load_q;
        count_d = count_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        rdata_d = rdata_q;

        if (en_q) begin
            if (!expire) begin
                count_d = count_q - CNT_W'(1);
            end else if (auto_q) begin
                count_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (wr_ctrl) begin
            {ie_d, auto_d, en_d} = data_wdata_i[2:0];
        end
        if (start) begin
            count_d = load_q;
        end
        if (wr_load) begin
            load_d = load_wr[CNT_W-1:0];
        end
        if (wr_count) begin
            count_d = count_wr[CNT_W-1:0];
        end

        if ((wr_stat && data_wdata_i[0]) || int_fin_i) begin
            pend_d = 1'b0;
        end
        if (wr_stat && data_wdata_i[1]) begin
            ovr_d = 1'b0;
        end
        // A fresh expiry must never be lost to a same-cycle acknowledge
        if (expire) begin
            pend_d = 1'b1;
            if (pend_q) begin
                ovr_d = 1'b1;
            end
        end

        if (rd) begin
            unique case (sel)
                2'd0: rdata_d = {29'b0, ie_q, auto_q, en_q};
                2'd1: rdata_d = load_ext;
                2'd2: rdata_d = count_ext;
                2'd3: rdata_d = {30'b0, ovr_q, pend_q};
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            en_q    <= en_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            rdata_q <= rdata_d;
        end
    end

    assign data_rdata_o = rdata_q;
    assign int_req_o    = pend_q & ie_q;

endmodule
